// File: rtl/seg595_display_arbiter.sv
// Round-robin owner of one 8-digit 2x74HC595 hex display: snapshots the owner's word per scan
// and bit-bangs segment/select bytes onto the 595 shift, data and latch pins.
module seg595_display_arbiter #(
    parameter int DIV   = 256,
    parameter int DWELL = 64
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [3:0]   req,
    input  logic [127:0] data_in,
    output logic [3:0]   gnt,
    output logic [1:0]   owner,
    output logic         frame_done,
    output logic         clk,
    output logic         dat,
    output logic         str
);

    localparam int DIV_W   = $clog2(DIV);
    localparam int DWELL_W = $clog2(DWELL + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(DWELL);
    localparam logic [5:0]         PH_LATCH   = 6'd32;
    localparam logic [5:0]         PH_LAST    = 6'd33;
    localparam logic [2:0]         DIGIT_LAST = 3'd7;

    typedef enum logic [1:0] {
        STEP_DATA,
        STEP_CLK_HI,
        STEP_LATCH,
        STEP_UNLATCH
    } step_e;

    function automatic logic [7:0] seg_of(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            4'hF:    seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         phase_q, phase_d;
    logic [2:0]         digit_q, digit_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [31:0]        snap_q, snap_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         owner_q, owner_d;
    logic               frame_done_q, frame_done_d;
    logic               clk_q, clk_d;
    logic               dat_q, dat_d;
    logic               str_q, str_d;

    logic               tick_s;
    logic               scan_start_s;
    logic               scan_end_s;
    logic [3:0]         nib_s;
    logic [7:0]         seg_s;
    logic [7:0]         sel_s;
    logic [15:0]        word_s;
    step_e              step_s;
    logic               owner_live_s;
    logic               others_s;
    logic               found_s;
    logic [1:0]         cand_s;
    logic [1:0]         idx_s;
    logic [DWELL_W-1:0] dwell_inc_s;

    // Serial tick divider and the digit/phase sequencer it steps
    always_comb begin
        tick_s       = (div_q == DIV_LAST);
        div_d        = tick_s ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
        scan_start_s = tick_s && (digit_q == 3'd0) && (phase_q == 6'd0);
        scan_end_s   = tick_s && (digit_q == DIGIT_LAST) && (phase_q == PH_LAST);
        phase_d      = phase_q;
        digit_d      = digit_q;
        if (tick_s) begin
            if (phase_q == PH_LAST) begin
                phase_d = 6'd0;
                digit_d = digit_q + 3'd1;
            end else begin
                phase_d = phase_q + 6'd1;
            end
        end else begin
            phase_d = phase_q;
            digit_d = digit_q;
        end
    end

    // Frame snapshot and the 16-bit word for the digit being shifted
    always_comb begin
        snap_d = snap_q;
        if (scan_start_s) begin
            snap_d = (gnt_q != 4'd0) ? data_in[{owner_q, 5'd0} +: 32] : 32'd0;
        end else begin
            snap_d = snap_q;
        end
        // snap_d feeds the word so digit 0 uses the fresh snapshot on its first tick
        nib_s  = snap_d[{digit_q, 2'b00} +: 4];
        seg_s  = (gnt_q == 4'd0) ? 8'hFF : seg_of(nib_s);
        sel_s  = 8'd1 << digit_q;
        word_s = {seg_s, sel_s};
    end

    // 595 pin sequencing: data/clock-low, clock-high, latch, unlatch
    always_comb begin
        clk_d = clk_q;
        dat_d = dat_q;
        str_d = str_q;
        if (phase_q < PH_LATCH) begin
            step_s = phase_q[0] ? STEP_CLK_HI : STEP_DATA;
        end else if (phase_q == PH_LATCH) begin
            step_s = STEP_LATCH;
        end else begin
            step_s = STEP_UNLATCH;
        end
        if (tick_s) begin
            case (step_s)
                STEP_DATA: begin
                    clk_d = 1'b0;
                    dat_d = word_s[4'd15 - phase_q[4:1]];
                end
                STEP_CLK_HI: begin
                    clk_d = 1'b1;
                end
                STEP_LATCH: begin
                    clk_d = 1'b0;
                    str_d = 1'b1;
                end
                STEP_UNLATCH: begin
                    str_d = 1'b0;
                end
                default: begin
                    clk_d = 1'b0;
                    str_d = 1'b0;
                end
            endcase
        end else begin
            clk_d = clk_q;
            dat_d = dat_q;
            str_d = str_q;
        end
    end

    // Scan-boundary arbitration with dwell and round-robin search
    always_comb begin
        frame_done_d = scan_end_s;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        dwell_d      = dwell_q;
        owner_live_s = (gnt_q != 4'd0) && req[owner_q];
        others_s     = |(req & ~(4'd1 << owner_q));
        dwell_inc_s  = (dwell_q == DWELL_MAX) ? DWELL_MAX : dwell_q + DWELL_W'(1);
        found_s      = 1'b0;
        cand_s       = owner_q;
        idx_s        = owner_q;
        // The fourth probe wraps back onto the current owner itself
        for (int k = 1; k <= 4; k++) begin
            idx_s = owner_q + 2'(k);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                cand_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        if (scan_end_s) begin
            if (owner_live_s) begin
                if ((dwell_inc_s == DWELL_MAX) && others_s) begin
                    gnt_d   = 4'd1 << cand_s;
                    owner_d = cand_s;
                    dwell_d = {DWELL_W{1'b0}};
                end else begin
                    dwell_d = dwell_inc_s;
                end
            end else if (found_s) begin
                gnt_d   = 4'd1 << cand_s;
                owner_d = cand_s;
                dwell_d = {DWELL_W{1'b0}};
            end else begin
                gnt_d   = 4'd0;
                dwell_d = {DWELL_W{1'b0}};
            end
        end else begin
            gnt_d   = gnt_q;
            owner_d = owner_q;
            dwell_d = dwell_q;
        end
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            div_q        <= {DIV_W{1'b0}};
            phase_q      <= 6'd0;
            digit_q      <= 3'd0;
            dwell_q      <= {DWELL_W{1'b0}};
            snap_q       <= 32'd0;
            gnt_q        <= 4'd0;
            owner_q      <= 2'd0;
            frame_done_q <= 1'b0;
            clk_q        <= 1'b0;
            dat_q        <= 1'b0;
            str_q        <= 1'b0;
        end else begin
            div_q        <= div_d;
            phase_q      <= phase_d;
            digit_q      <= digit_d;
            dwell_q      <= dwell_d;
            snap_q       <= snap_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            frame_done_q <= frame_done_d;
            clk_q        <= clk_d;
            dat_q        <= dat_d;
            str_q        <= str_d;
        end
    end

    assign gnt        = gnt_q;
    assign owner      = owner_q;
    assign frame_done = frame_done_q;
    assign clk        = clk_q;
    assign dat        = dat_q;
    assign str        = str_q;

endmodule

// File: tb/tb_seg595_display_arbiter.sv
// Bench for seg595_display_arbiter (DIV=2, DWELL=2): scan-level reference model plus a 595
// shift-register decoder, a vector table of arbitration steps and hand-written corner sequences.
module tb_seg595_display_arbiter;

    localparam int DIV   = 2;
    localparam int DWELL = 2;
    localparam int SCAN  = 8 * 34 * DIV;
    localparam int NV    = 16;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic [3:0]   req;
    logic [127:0] data_in;
    logic [3:0]   gnt;
    logic [1:0]   owner;
    logic         frame_done;
    logic         clk;
    logic         dat;
    logic         str;

    seg595_display_arbiter #(.DIV(DIV), .DWELL(DWELL)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .req        (req),
        .data_in    (data_in),
        .gnt        (gnt),
        .owner      (owner),
        .frame_done (frame_done),
        .clk        (clk),
        .dat        (dat),
        .str        (str)
    );

    always #5 sys_clk = ~sys_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] seg_ref(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Reference model state (scan-level) and 595 decoder state
    int          n = 0;
    int          bnd_cnt = 0;
    logic [3:0]  m_gnt = 4'd0;
    int          m_owner = 0;
    int          m_dwell = 0;
    logic [31:0] m_snap = 32'd0;
    logic [15:0] sr = 16'd0;
    logic        prev_clk = 1'b0;
    logic        prev_str = 1'b0;
    int          lat_in_scan = 0;
    logic [15:0] lat_word [8];

    task automatic model_pick(input logic [3:0] r);
        int pick = -1;
        for (int k = 1; k <= 4; k++)
            if (pick < 0 && r[(m_owner + k) % 4]) pick = (m_owner + k) % 4;
        if (pick >= 0) begin
            m_gnt   = 4'd1 << pick;
            m_owner = pick;
        end else begin
            m_gnt = 4'd0;
        end
        m_dwell = 0;
    endtask

    task automatic model_boundary(input logic [3:0] r);
        if (m_gnt != 4'd0 && r[m_owner]) begin
            m_dwell = (m_dwell < DWELL) ? m_dwell + 1 : DWELL;
            if (m_dwell == DWELL && (r & ~(4'd1 << m_owner)) != 4'd0) model_pick(r);
        end else begin
            model_pick(r);
        end
    endtask

    // Monitor: advances the model per sys_clk edge and checks the DUT just after it
    initial begin
        int pos;
        logic exp_fd;
        logic [15:0] exp_w;
        forever begin
            @(posedge sys_clk);
            if (!sys_rst_n) begin
                n = 0; m_gnt = 4'd0; m_owner = 0; m_dwell = 0; m_snap = 32'd0;
                sr = 16'd0; lat_in_scan = 0;
                #1;
                check("reset_outs", {22'd0, gnt, owner, frame_done, clk, dat, str}, 32'd0);
                prev_clk = clk;
                prev_str = str;
            end else begin
                pos = n % SCAN;
                if (pos == 1) m_snap = (m_gnt != 4'd0) ? data_in[32*m_owner +: 32] : 32'd0;
                exp_fd = (pos == SCAN - 1);
                if (exp_fd) begin
                    check("latches_per_scan", lat_in_scan, 32'd8);
                    lat_in_scan = 0;
                    model_boundary(req);
                    bnd_cnt++;
                end
                n++;
                #1;
                if (clk && !prev_clk) sr = {sr[14:0], dat};
                if (str && !prev_str) begin
                    exp_w = {(m_gnt != 4'd0) ? seg_ref(m_snap[4*(lat_in_scan % 8) +: 4]) : 8'hFF,
                             8'(1 << (lat_in_scan % 8))};
                    check("latched_word", {16'd0, sr}, {16'd0, exp_w});
                    lat_word[lat_in_scan % 8] = sr;
                    lat_in_scan++;
                end
                prev_clk = clk;
                prev_str = str;
                check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
                check("gnt", {28'd0, gnt}, {28'd0, m_gnt});
                check("owner", {30'd0, owner}, {30'd0, 2'(m_owner)});
            end
        end
    end

    task automatic run_scans(input int k);
        int target = bnd_cnt + k;
        int guard = 0;
        while (bnd_cnt < target && guard < k * SCAN + 64) begin
            @(negedge sys_clk);
            guard++;
        end
        check("scan_reached", {31'd0, bnd_cnt >= target}, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        set_data;
        int          src;
        logic [31:0] word;
        int          scans;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_owner;
        logic        chk_lat;
        logic [15:0] lat0;
        logic [15:0] lat7;
    } vec_t;

    vec_t tbl [NV];

    initial begin
        int g;
        tbl[0]  = '{4'b0000, 1'b0, 0, 32'h0,         1, 4'b0000, 2'd0, 1'b1, 16'hFF01, 16'hFF80};
        tbl[1]  = '{4'b0001, 1'b1, 0, 32'h89AB_CDEF, 1, 4'b0001, 2'd0, 1'b0, 16'h0,    16'h0};
        tbl[2]  = '{4'b1111, 1'b0, 0, 32'h0,         1, 4'b0001, 2'd0, 1'b1, 16'h8E01, 16'h8080};
        tbl[3]  = '{4'b1111, 1'b0, 0, 32'h0,         1, 4'b0010, 2'd1, 1'b0, 16'h0,    16'h0};
        tbl[4]  = '{4'b1111, 1'b0, 0, 32'h0,         1, 4'b0010, 2'd1, 1'b0, 16'h0,    16'h0};
        tbl[5]  = '{4'b1111, 1'b0, 0, 32'h0,         1, 4'b0100, 2'd2, 1'b0, 16'h0,    16'h0};
        tbl[6]  = '{4'b1111, 1'b0, 0, 32'h0,         1, 4'b0100, 2'd2, 1'b0, 16'h0,    16'h0};
        tbl[7]  = '{4'b1111, 1'b0, 0, 32'h0,         1, 4'b1000, 2'd3, 1'b0, 16'h0,    16'h0};
        tbl[8]  = '{4'b1111, 1'b0, 0, 32'h0,         1, 4'b1000, 2'd3, 1'b0, 16'h0,    16'h0};
        tbl[9]  = '{4'b1111, 1'b0, 0, 32'h0,         1, 4'b0001, 2'd0, 1'b0, 16'h0,    16'h0};
        tbl[10] = '{4'b0000, 1'b0, 0, 32'h0,         1, 4'b0000, 2'd0, 1'b0, 16'h0,    16'h0};
        tbl[11] = '{4'b0100, 1'b0, 0, 32'h0,         1, 4'b0100, 2'd2, 1'b0, 16'h0,    16'h0};
        tbl[12] = '{4'b0110, 1'b0, 0, 32'h0,         3, 4'b0010, 2'd1, 1'b0, 16'h0,    16'h0};
        tbl[13] = '{4'b0100, 1'b0, 0, 32'h0,         1, 4'b0100, 2'd2, 1'b0, 16'h0,    16'h0};
        tbl[14] = '{4'b0100, 1'b0, 0, 32'h0,         3, 4'b0100, 2'd2, 1'b0, 16'h0,    16'h0};
        tbl[15] = '{4'b0101, 1'b0, 0, 32'h0,         1, 4'b0001, 2'd0, 1'b0, 16'h0,    16'h0};

        sys_rst_n = 1'b0;
        req       = 4'd0;
        data_in   = 128'd0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            req = tbl[i].req;
            if (tbl[i].set_data) data_in[32*tbl[i].src +: 32] = tbl[i].word;
            run_scans(tbl[i].scans);
            check($sformatf("vec%0d_gnt", i), {28'd0, gnt}, {28'd0, tbl[i].exp_gnt});
            check($sformatf("vec%0d_owner", i), {30'd0, owner}, {30'd0, tbl[i].exp_owner});
            if (tbl[i].chk_lat) begin
                check($sformatf("vec%0d_digit0", i), {16'd0, lat_word[0]}, {16'd0, tbl[i].lat0});
                check($sformatf("vec%0d_digit7", i), {16'd0, lat_word[7]}, {16'd0, tbl[i].lat7});
            end
        end

        // Owner 2 drops its request mid-scan; search restarts from 3 with dwell cleared
        req = 4'b0100;
        run_scans(1);
        check("drop_setup_gnt", {28'd0, gnt}, 32'h4);
        repeat (272) @(negedge sys_clk);
        req = 4'b1001;
        run_scans(1);
        check("drop_gnt", {28'd0, gnt}, 32'h8);
        check("drop_owner", {30'd0, owner}, 32'd3);
        run_scans(1);
        check("drop_dwell1_gnt", {28'd0, gnt}, 32'h8);
        run_scans(1);
        check("drop_dwell2_gnt", {28'd0, gnt}, 32'h1);

        // Owner's word changes mid-scan: the running frame must stay untorn
        data_in[64 +: 32] = 32'h0123_4567;
        req = 4'b0100;
        run_scans(1);
        check("tear_setup_owner", {30'd0, owner}, 32'd2);
        repeat (300) @(negedge sys_clk);
        data_in[64 +: 32] = 32'hFEDC_BA98;
        run_scans(1);
        check("tear_old_digit0", {16'd0, lat_word[0]}, 32'hF801);
        check("tear_old_digit7", {16'd0, lat_word[7]}, 32'hC080);
        run_scans(1);
        check("tear_new_digit0", {16'd0, lat_word[0]}, 32'h8001);
        check("tear_new_digit7", {16'd0, lat_word[7]}, 32'h8E80);

        // Reset at phase 17 of digit 7 (clk high, dat = sel[7] = 1)
        g = 0;
        while (n % SCAN != 512 && g < 2 * SCAN) begin
            @(negedge sys_clk);
            g++;
        end
        check("pre_reset_pins", {29'd0, clk, dat, str}, 32'd6);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("mid_shift_reset", {25'd0, gnt, clk, dat, str}, 32'd0);
        sys_rst_n = 1'b1;
        run_scans(1);
        check("restart_digit0", {16'd0, lat_word[0]}, 32'hFF01);
        check("restart_digit7", {16'd0, lat_word[7]}, 32'hFF80);
        check("restart_gnt", {28'd0, gnt}, 32'h4);

        // Random requests and data at random points, checked by the monitor's model
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            req     = 4'($urandom);
            data_in = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(150, 900)) @(negedge sys_clk);
        end
        run_scans(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
